// File: rtl/multicycle_ctrl_pkg.sv
// Shared definitions for the multicycle controller: opcodes, FSM states and
// the datapath mux/ALU-op encodings driven by the controller.
package multicycle_ctrl_pkg;

  localparam logic [6:0] R_TYPE       = 7'b0110011;
  localparam logic [6:0] LW           = 7'b0000011;
  localparam logic [6:0] SW           = 7'b0100011;
  localparam logic [6:0] BR           = 7'b1100011;
  localparam logic [6:0] INT_IMED_REG = 7'b0010011;

  localparam logic [2:0] F3_BEQ = 3'b000;
  localparam logic [2:0] F3_BNE = 3'b001;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEMADDR,
    S_MEMREAD,
    S_MEMWB,
    S_MEMWRITE,
    S_EXECR,
    S_EXECI,
    S_ALUWB,
    S_BRANCH,
    S_TRAP
  } state_t;

  typedef enum logic [1:0] {
    SRCA_PC    = 2'b00,
    SRCA_OLDPC = 2'b01,
    SRCA_REGA  = 2'b10
  } alu_src_a_t;

  typedef enum logic [1:0] {
    SRCB_REGB = 2'b00,
    SRCB_IMM  = 2'b01,
    SRCB_FOUR = 2'b10
  } alu_src_b_t;

  typedef enum logic [1:0] {
    ALUOP_ADD    = 2'b00,
    ALUOP_BRANCH = 2'b01,
    ALUOP_FUNCT  = 2'b10
  } alu_op_t;

endpackage

// File: rtl/multicycle_ctrl.sv
// Multicycle RISC-V style main controller: one state register and a
// combinational next-state/output decoder. ALU-function decode lives elsewhere.
//
// state      | meaning
// FETCH      | read instruction at PC, PC+4 written when memory answers
// DECODE     | branch target (OldPC+imm) into ALUOut, dispatch on opcode
// MEMADDR    | RegA+imm effective address
// MEMREAD    | load access, wait for MemReady
// MEMWB      | write load data to register file, retire
// MEMWRITE   | store access, retire when memory answers
// EXECR      | RegA op RegB
// EXECI      | RegA op imm
// ALUWB      | write ALU result to register file, retire
// BRANCH     | compare, conditionally load PC from ALUOut, retire
// TRAP       | illegal instruction, held until reset
module multicycle_ctrl
  import multicycle_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] Opcode,
  input  logic [2:0] Funct3,
  input  logic       Zero,
  input  logic       MemReady,
  output logic       MemReq,
  output logic       MemWrite,
  output logic       IorD,
  output logic       IRWrite,
  output logic       PCWrite,
  output logic       PCSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic       RegWrite,
  output logic       MemtoReg,
  output logic       InstrDone,
  output logic       Illegal
);

  state_t state, state_next;

  always_ff @(posedge clk) begin
    if (reset) state <= S_FETCH;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    MemReq     = 1'b0;
    MemWrite   = 1'b0;
    IorD       = 1'b0;
    IRWrite    = 1'b0;
    PCWrite    = 1'b0;
    PCSrc      = 1'b0;
    ALUSrcA    = SRCA_PC;
    ALUSrcB    = SRCB_REGB;
    ALUOp      = ALUOP_ADD;
    RegWrite   = 1'b0;
    MemtoReg   = 1'b0;
    InstrDone  = 1'b0;
    Illegal    = 1'b0;

    case (state)
      S_FETCH: begin
        MemReq  = 1'b1;
        ALUSrcB = SRCB_FOUR;
        IRWrite = MemReady;
        PCWrite = MemReady;
        if (MemReady) state_next = S_DECODE;
      end
      S_DECODE: begin
        ALUSrcA = SRCA_OLDPC;
        ALUSrcB = SRCB_IMM;
        case (Opcode)
          LW, SW:       state_next = S_MEMADDR;
          R_TYPE:       state_next = S_EXECR;
          INT_IMED_REG: state_next = S_EXECI;
          BR:           state_next = S_BRANCH;
          default:      state_next = S_TRAP;
        endcase
      end
      S_MEMADDR: begin
        ALUSrcA    = SRCA_REGA;
        ALUSrcB    = SRCB_IMM;
        state_next = (Opcode == LW) ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        MemReq = 1'b1;
        IorD   = 1'b1;
        if (MemReady) state_next = S_MEMWB;
      end
      S_MEMWB: begin
        RegWrite   = 1'b1;
        MemtoReg   = 1'b1;
        InstrDone  = 1'b1;
        state_next = S_FETCH;
      end
      S_MEMWRITE: begin
        MemReq   = 1'b1;
        MemWrite = 1'b1;
        IorD     = 1'b1;
        if (MemReady) begin
          InstrDone  = 1'b1;
          state_next = S_FETCH;
        end
      end
      S_EXECR: begin
        ALUSrcA    = SRCA_REGA;
        ALUSrcB    = SRCB_REGB;
        ALUOp      = ALUOP_FUNCT;
        state_next = S_ALUWB;
      end
      S_EXECI: begin
        ALUSrcA    = SRCA_REGA;
        ALUSrcB    = SRCB_IMM;
        ALUOp      = ALUOP_FUNCT;
        state_next = S_ALUWB;
      end
      S_ALUWB: begin
        RegWrite   = 1'b1;
        InstrDone  = 1'b1;
        state_next = S_FETCH;
      end
      S_BRANCH: begin
        ALUSrcA = SRCA_REGA;
        ALUSrcB = SRCB_REGB;
        ALUOp   = ALUOP_BRANCH;
        PCSrc   = 1'b1;
        // Unsupported compare kinds trap without touching PC or retiring
        case (Funct3)
          F3_BEQ: begin
            PCWrite    = Zero;
            InstrDone  = 1'b1;
            state_next = S_FETCH;
          end
          F3_BNE: begin
            PCWrite    = ~Zero;
            InstrDone  = 1'b1;
            state_next = S_FETCH;
          end
          default: state_next = S_TRAP;
        endcase
      end
      S_TRAP: begin
        Illegal = 1'b1;
      end
      default: state_next = S_FETCH;
    endcase

    // Reset abandons any in-flight request and suppresses all strobes
    if (reset) begin
      MemReq    = 1'b0;
      MemWrite  = 1'b0;
      IorD      = 1'b0;
      IRWrite   = 1'b0;
      PCWrite   = 1'b0;
      PCSrc     = 1'b0;
      ALUSrcA   = 2'b00;
      ALUSrcB   = 2'b00;
      ALUOp     = 2'b00;
      RegWrite  = 1'b0;
      MemtoReg  = 1'b0;
      InstrDone = 1'b0;
      Illegal   = 1'b0;
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: builds a per-cycle plan of inputs and
// expected outputs from the instruction-level rules, then replays and compares.
module tb_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] Opcode;
  logic [2:0] Funct3;
  logic       Zero;
  logic       MemReady;
  logic       MemReq, MemWrite, IorD, IRWrite, PCWrite, PCSrc;
  logic [1:0] ALUSrcA, ALUSrcB, ALUOp;
  logic       RegWrite, MemtoReg, InstrDone, Illegal;

  multicycle_ctrl dut (
    .clk(clk), .reset(reset), .Opcode(Opcode), .Funct3(Funct3), .Zero(Zero),
    .MemReady(MemReady), .MemReq(MemReq), .MemWrite(MemWrite), .IorD(IorD),
    .IRWrite(IRWrite), .PCWrite(PCWrite), .PCSrc(PCSrc), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .RegWrite(RegWrite), .MemtoReg(MemtoReg),
    .InstrDone(InstrDone), .Illegal(Illegal)
  );

  always #5 clk = ~clk;

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_BR  = 7'b1100011;
  localparam logic [6:0] OP_BAD = 7'b1111111;

  typedef struct {
    logic        rst;
    logic        rdy;
    logic        zero;
    logic [6:0]  opc;
    logic [2:0]  f3;
    logic [15:0] exp;
    int          tag;
  } ent_t;

  ent_t plan[$];
  logic [6:0] cur_opc;
  logic [2:0] cur_f3;
  logic       cur_zero;
  int         cur_tag;
  int checks = 0;
  int failures = 0;
  int done_cnt = 0;
  int ir_cnt = 0;

  // Output word: {MemReq,MemWrite,IorD,IRWrite,PCWrite,PCSrc,A,B,Op,RegWrite,MemtoReg,InstrDone,Illegal}
  function automatic logic [15:0] w(input logic req, wr, iord, irw, pcw, pcsrc,
                                    input logic [1:0] a, b, op,
                                    input logic rw, m2r, done, ill);
    return {req, wr, iord, irw, pcw, pcsrc, a, b, op, rw, m2r, done, ill};
  endfunction

  function automatic logic [15:0] fetch_w(input logic rdy);
    return w(1, 0, 0, rdy, rdy, 0, 2'b00, 2'b10, 2'b00, 0, 0, 0, 0);
  endfunction
  function automatic logic [15:0] decode_w();
    return w(0, 0, 0, 0, 0, 0, 2'b01, 2'b01, 2'b00, 0, 0, 0, 0);
  endfunction
  function automatic logic [15:0] memaddr_w();
    return w(0, 0, 0, 0, 0, 0, 2'b10, 2'b01, 2'b00, 0, 0, 0, 0);
  endfunction
  function automatic logic [15:0] memread_w();
    return w(1, 0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0);
  endfunction
  function automatic logic [15:0] memwb_w();
    return w(0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 1, 1, 1, 0);
  endfunction
  function automatic logic [15:0] memwrite_w(input logic rdy);
    return w(1, 1, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0, 0, rdy, 0);
  endfunction
  function automatic logic [15:0] exec_w(input logic imm);
    return w(0, 0, 0, 0, 0, 0, 2'b10, imm ? 2'b01 : 2'b00, 2'b10, 0, 0, 0, 0);
  endfunction
  function automatic logic [15:0] aluwb_w();
    return w(0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 1, 0, 1, 0);
  endfunction
  function automatic logic [15:0] branch_w(input logic pcw, done);
    return w(0, 0, 0, 0, pcw, 1, 2'b10, 2'b00, 2'b01, 0, 0, done, 0);
  endfunction
  function automatic logic [15:0] trap_w();
    return w(0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0, 0, 0, 1);
  endfunction

  // MemReady toggles in states without a request; the DUT must ignore it there
  function automatic logic noise();
    return logic'(plan.size() % 2);
  endfunction

  task automatic push(input logic rst, input logic rdy, input logic [15:0] exp);
    ent_t e;
    e.rst = rst; e.rdy = rdy; e.zero = cur_zero; e.opc = cur_opc;
    e.f3 = cur_f3; e.exp = exp; e.tag = cur_tag;
    plan.push_back(e);
  endtask

  task automatic plan_instr(input int tag, input logic [6:0] opc, input logic [2:0] f3,
                            input logic zero, input int fst, input int mst,
                            output int len);
    int n0;
    n0 = plan.size();
    cur_tag = tag; cur_opc = opc; cur_f3 = f3; cur_zero = zero;
    repeat (fst) push(0, 0, fetch_w(0));
    push(0, 1, fetch_w(1));
    push(0, noise(), decode_w());
    if (opc == OP_LW || opc == OP_SW) begin
      push(0, noise(), memaddr_w());
      repeat (mst) push(0, 0, (opc == OP_LW) ? memread_w() : memwrite_w(0));
      if (opc == OP_LW) begin
        push(0, 1, memread_w());
        push(0, noise(), memwb_w());
      end else begin
        push(0, 1, memwrite_w(1));
      end
    end else if (opc == OP_R || opc == OP_I) begin
      push(0, noise(), exec_w(opc == OP_I));
      push(0, noise(), aluwb_w());
    end else if (opc == OP_BR) begin
      if (f3 == 3'b000)      push(0, noise(), branch_w(zero, 1));
      else if (f3 == 3'b001) push(0, noise(), branch_w(~zero, 1));
      else                   push(0, noise(), branch_w(0, 0));
    end
    len = plan.size() - n0;
  endtask

  task automatic check_int(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      failures++;
      $display("FAIL %s got %0d want %0d", name, got, want);
    end
  endtask

  int len_add, len_addi, len_lw_st, len_lw, len_sw, len_sw_st;
  int len_beq1, len_beq0, len_bne0, len_bne1, len_tmp;

  initial begin
    logic [15:0] got;
    reset = 1'b1; Opcode = '0; Funct3 = '0; Zero = 1'b0; MemReady = 1'b0;
    cur_opc = '0; cur_f3 = '0; cur_zero = 1'b0; cur_tag = 0;

    push(1, 1, 16'h0);
    push(1, 0, 16'h0);
    plan_instr(1, OP_R, 3'b000, 0, 0, 0, len_add);
    plan_instr(2, OP_I, 3'b000, 1, 0, 0, len_addi);
    plan_instr(3, OP_LW, 3'b010, 0, 3, 2, len_lw_st);
    plan_instr(4, OP_LW, 3'b010, 1, 0, 0, len_lw);
    plan_instr(5, OP_SW, 3'b010, 0, 0, 0, len_sw);
    plan_instr(6, OP_SW, 3'b010, 0, 2, 1, len_sw_st);
    plan_instr(7, OP_BR, 3'b000, 1, 0, 0, len_beq1);
    plan_instr(8, OP_BR, 3'b000, 0, 0, 0, len_beq0);
    plan_instr(9, OP_BR, 3'b001, 0, 0, 0, len_bne0);
    plan_instr(10, OP_BR, 3'b001, 1, 0, 0, len_bne1);

    // store abandoned by reset while waiting on memory
    cur_tag = 11; cur_opc = OP_SW; cur_f3 = 3'b010; cur_zero = 0;
    push(0, 1, fetch_w(1));
    push(0, 1, decode_w());
    push(0, 1, memaddr_w());
    push(0, 0, memwrite_w(0));
    push(0, 0, memwrite_w(0));
    push(1, 0, 16'h0);
    cur_tag = 12;
    push(0, 0, fetch_w(0));
    plan_instr(12, OP_R, 3'b000, 0, 0, 0, len_tmp);

    // unsupported branch compare traps
    plan_instr(13, OP_BR, 3'b010, 1, 0, 0, len_tmp);
    repeat (5) push(0, noise(), trap_w());
    push(1, 1, 16'h0);
    plan_instr(14, OP_R, 3'b000, 0, 0, 0, len_tmp);

    // illegal opcode
    plan_instr(15, OP_BAD, 3'b000, 0, 0, 0, len_tmp);
    repeat (20) push(0, noise(), trap_w());
    push(1, 0, 16'h0);
    plan_instr(16, OP_LW, 3'b000, 0, 1, 1, len_tmp);

    foreach (plan[i]) begin
      @(posedge clk);
      #1;
      reset = plan[i].rst; MemReady = plan[i].rdy; Zero = plan[i].zero;
      Opcode = plan[i].opc; Funct3 = plan[i].f3;
      @(negedge clk);
      got = {MemReq, MemWrite, IorD, IRWrite, PCWrite, PCSrc, ALUSrcA, ALUSrcB,
             ALUOp, RegWrite, MemtoReg, InstrDone, Illegal};
      checks++;
      if (got !== plan[i].exp) begin
        failures++;
        $display("FAIL step%0d instr%0d outputs got %h want %h", i, plan[i].tag, got, plan[i].exp);
      end
      if (InstrDone === 1'b1) done_cnt++;
      if (IRWrite === 1'b1) ir_cnt++;
    end

    check_int("len_add", len_add, 4);
    check_int("len_addi", len_addi, 4);
    check_int("len_lw_stalled", len_lw_st, 10);
    check_int("len_lw", len_lw, 5);
    check_int("len_sw", len_sw, 4);
    check_int("len_sw_stalled", len_sw_st, 7);
    check_int("len_beq_z1", len_beq1, 3);
    check_int("len_beq_z0", len_beq0, 3);
    check_int("len_bne_z0", len_bne0, 3);
    check_int("len_bne_z1", len_bne1, 3);
    check_int("retire_count", done_cnt, 13);
    check_int("irwrite_count", ir_cnt, 16);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
